// File: rtl/axis_fft_peak_detector.sv
// axis_fft_peak_detector
// Consumes the xFFT result stream one complex bin per beat, forms |X|^2 for
// every bin and reports the strongest bin of each frame on a valid/ready
// result port together with its power, a framing-error flag and a running
// frame count.
//
// Pipeline timing (frame-end beat accepted in cycle c):
//   c+1 : stage 1 holds re^2 and im^2
//   c+2 : result registers hold peak_bin/peak_pwr/peak_err, peak_valid high
// Stage 2 sums the squares and folds the sum into the running maximum in
// the same cycle, so the result lands directly from that stage.

module axis_fft_peak_detector #(
    parameter int P_DATA_WID       = 32,
    parameter int P_FFT_NUM_SAMPLE = 256,
    parameter int P_SKIP_DC        = 1
) (
    input  logic                                  axis_clk,
    input  logic                                  axis_reset,
    // Spectrum input stream
    input  logic                                  s_axis_tvalid,
    output logic                                  s_axis_tready,
    input  logic                                  s_axis_tlast,
    input  logic [2*P_DATA_WID-1:0]               s_axis_tdata,
    // Peak result port
    output logic                                  peak_valid,
    input  logic                                  peak_ready,
    output logic [$clog2(P_FFT_NUM_SAMPLE)-1:0]   peak_bin,
    output logic [2*P_DATA_WID-1:0]               peak_pwr,
    output logic                                  peak_err,
    output logic [15:0]                           frame_cnt
);

    // P_FFT_NUM_SAMPLE is expected to be a power of two and at least 8: the
    // bin counter wraps naturally and in-flight beats can never close a
    // second frame while a result is stalled.
    localparam int L_BIN_WID = $clog2(P_FFT_NUM_SAMPLE);
    localparam int L_PWR_WID = 2 * P_DATA_WID;
    // A square of a W-bit signed value is non-negative and fits in 2W-1 bits.
    localparam int L_SQ_WID  = L_PWR_WID - 1;

    localparam logic [L_BIN_WID-1:0] L_LAST_BIN = L_BIN_WID'(P_FFT_NUM_SAMPLE - 1);
    localparam logic [L_BIN_WID-1:0] L_BIN_ONE  = L_BIN_WID'(1);

    // ------------------------------------------------------------------
    // Input handshake and framing
    // ------------------------------------------------------------------
    logic                      w_accept;
    logic                      w_at_last_bin;
    logic                      w_frame_end;
    logic                      w_frame_err;

    logic signed [P_DATA_WID-1:0] w_re;
    logic signed [P_DATA_WID-1:0] w_im;
    logic signed [L_PWR_WID-1:0]  w_re_ext;
    logic signed [L_PWR_WID-1:0]  w_im_ext;
    logic [L_SQ_WID-1:0]          w_re_sq;
    logic [L_SQ_WID-1:0]          w_im_sq;

    logic [L_BIN_WID-1:0]      r_bin_cnt;

    // Stage 1 registers
    logic                      r_s1_vld;
    logic [L_SQ_WID-1:0]       r_s1_re_sq;
    logic [L_SQ_WID-1:0]       r_s1_im_sq;
    logic [L_BIN_WID-1:0]      r_s1_bin;
    logic                      r_s1_end;
    logic                      r_s1_err;

    // Stage 2 / running maximum
    logic [L_PWR_WID-1:0]      w_pwr;
    logic                      w_is_dc;
    logic [L_PWR_WID-1:0]      w_cand_pwr;
    logic [L_BIN_WID-1:0]      w_cand_bin;
    logic [L_PWR_WID-1:0]      r_max_pwr;
    logic [L_BIN_WID-1:0]      r_max_bin;

    // Result registers
    logic                      r_peak_valid;
    logic [L_BIN_WID-1:0]      r_peak_bin;
    logic [L_PWR_WID-1:0]      r_peak_pwr;
    logic                      r_peak_err;
    logic [15:0]               r_frame_cnt;

    // Input stalls only while a result is waiting to be taken.
    assign s_axis_tready = ~(r_peak_valid & ~peak_ready);
    assign w_accept      = s_axis_tvalid & s_axis_tready;

    // A frame closes on tlast or on the last bin index, whichever comes
    // first; disagreement between the two marks the frame as malformed.
    assign w_at_last_bin = (r_bin_cnt == L_LAST_BIN);
    assign w_frame_end   = s_axis_tlast | w_at_last_bin;
    assign w_frame_err   = s_axis_tlast ^ w_at_last_bin;

    assign w_re = s_axis_tdata[P_DATA_WID-1:0];
    assign w_im = s_axis_tdata[2*P_DATA_WID-1:P_DATA_WID];

    // Sign-extend to full width so the product is computed without loss.
    assign w_re_ext = {{P_DATA_WID{w_re[P_DATA_WID-1]}}, w_re};
    assign w_im_ext = {{P_DATA_WID{w_im[P_DATA_WID-1]}}, w_im};
    assign w_re_sq  = L_SQ_WID'(w_re_ext * w_re_ext);
    assign w_im_sq  = L_SQ_WID'(w_im_ext * w_im_ext);

    // Bin counter: advances per accepted beat, restarts at every frame end.
    always_ff @(posedge axis_clk or posedge axis_reset) begin
        if (axis_reset) begin
            r_bin_cnt <= '0;
        end else if (w_accept) begin
            if (w_frame_end) begin
                r_bin_cnt <= '0;
            end else begin
                r_bin_cnt <= r_bin_cnt + L_BIN_ONE;
            end
        end
    end

    // Stage 1 valid: set only by an accepted beat so a stall freezes intake.
    always_ff @(posedge axis_clk or posedge axis_reset) begin
        if (axis_reset) begin
            r_s1_vld <= 1'b0;
        end else begin
            r_s1_vld <= w_accept;
        end
    end

    // Stage 1 payload: squares plus the framing info that rides with them.
    always_ff @(posedge axis_clk or posedge axis_reset) begin
        if (axis_reset) begin
            r_s1_re_sq <= '0;
            r_s1_im_sq <= '0;
            r_s1_bin   <= '0;
            r_s1_end   <= 1'b0;
            r_s1_err   <= 1'b0;
        end else if (w_accept) begin
            r_s1_re_sq <= w_re_sq;
            r_s1_im_sq <= w_im_sq;
            r_s1_bin   <= r_bin_cnt;
            r_s1_end   <= w_frame_end;
            r_s1_err   <= w_frame_err;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: power and running maximum
    // ------------------------------------------------------------------
    // Zero-extend the squares by one bit; the sum cannot overflow.
    assign w_pwr   = {1'b0, r_s1_re_sq} + {1'b0, r_s1_im_sq};
    assign w_is_dc = (r_s1_bin == '0);

    // Maximum including the beat currently in stage 2. Bin 0 always opens a
    // frame, so it also re-seeds the maximum; strict compare keeps the lowest
    // index on ties.
    always_comb begin
        w_cand_pwr = r_max_pwr;
        w_cand_bin = r_max_bin;
        if (w_is_dc) begin
            w_cand_bin = '0;
            if (P_SKIP_DC != 0) begin
                w_cand_pwr = '0;
            end else begin
                w_cand_pwr = w_pwr;
            end
        end else if (w_pwr > r_max_pwr) begin
            w_cand_pwr = w_pwr;
            w_cand_bin = r_s1_bin;
        end
    end

    // Running maximum register, advanced once per beat leaving stage 1.
    always_ff @(posedge axis_clk or posedge axis_reset) begin
        if (axis_reset) begin
            r_max_pwr <= '0;
            r_max_bin <= '0;
        end else if (r_s1_vld) begin
            r_max_pwr <= w_cand_pwr;
            r_max_bin <= w_cand_bin;
        end
    end

    // ------------------------------------------------------------------
    // Result port
    // ------------------------------------------------------------------
    // A landing result wins over a same-cycle handshake, so a back-to-back
    // result keeps peak_valid high with the new values.
    always_ff @(posedge axis_clk or posedge axis_reset) begin
        if (axis_reset) begin
            r_peak_valid <= 1'b0;
            r_peak_bin   <= '0;
            r_peak_pwr   <= '0;
            r_peak_err   <= 1'b0;
            r_frame_cnt  <= '0;
        end else if (r_s1_vld && r_s1_end) begin
            r_peak_valid <= 1'b1;
            r_peak_bin   <= w_cand_bin;
            r_peak_pwr   <= w_cand_pwr;
            r_peak_err   <= r_s1_err;
            r_frame_cnt  <= r_frame_cnt + 16'd1;
        end else if (r_peak_valid && peak_ready) begin
            r_peak_valid <= 1'b0;
        end
    end

    assign peak_valid = r_peak_valid;
    assign peak_bin   = r_peak_bin;
    assign peak_pwr   = r_peak_pwr;
    assign peak_err   = r_peak_err;
    assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_axis_fft_peak_detector.sv
// Testbench for axis_fft_peak_detector: directed and randomized spectra,
// reference model computes each frame's peak from the list of bin powers.

module tb_axis_fft_peak_detector;

    localparam int W    = 32;
    localparam int N    = 256;
    localparam int SKIP = 1;
    localparam int BW   = $clog2(N);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          s_axis_tlast = 1'b0;
    logic [2*W-1:0] s_axis_tdata = '0;
    logic          peak_valid;
    logic          peak_ready = 1'b1;
    logic [BW-1:0] peak_bin;
    logic [2*W-1:0] peak_pwr;
    logic          peak_err;
    logic [15:0]   frame_cnt;

    axis_fft_peak_detector #(
        .P_DATA_WID       (W),
        .P_FFT_NUM_SAMPLE (N),
        .P_SKIP_DC        (SKIP)
    ) dut (
        .axis_clk      (clk),
        .axis_reset    (rst),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tdata  (s_axis_tdata),
        .peak_valid    (peak_valid),
        .peak_ready    (peak_ready),
        .peak_bin      (peak_bin),
        .peak_pwr      (peak_pwr),
        .peak_err      (peak_err),
        .frame_cnt     (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint unsigned bin;
        longint unsigned pwr;
        longint unsigned err;
        longint unsigned fcnt;
        longint unsigned end_cyc;
    } exp_t;

    exp_t            sb_q[$];
    longint unsigned m_pwr[$];
    int unsigned     m_fcnt = 0;
    int              n_checks = 0;
    int              n_pass = 0;
    longint unsigned cyc = 0;
    int              rdy_mode = 0;
    bit              gap_en = 1'b0;
    bit              mon_prev = 1'b0;
    longint unsigned last_bin, last_pwr, last_err, last_fcnt;
    logic [31:0]     f_re [N];
    logic [31:0]     f_im [N];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint unsigned act,
                         input longint unsigned exp_v);
        n_checks++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: event did not occur as required", name);
    endtask

    task automatic finish_bench();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    endtask

    function automatic longint unsigned bin_pwr(input logic [31:0] re, input logic [31:0] im);
        longint sr;
        longint si;
        sr = longint'($signed(re));
        si = longint'($signed(im));
        return longint'(sr * sr) + longint'(si * si);
    endfunction

    // Reference model: collect bin powers; at frame end pick the strongest
    // non-DC bin (lowest index on ties, bin 0 / power 0 if none beats zero).
    task automatic model_accept(input logic [31:0] re, input logic [31:0] im, input bit last);
        bit   at_last;
        exp_t e;
        at_last = (m_pwr.size() == N - 1);
        m_pwr.push_back(bin_pwr(re, im));
        if (last || at_last) begin
            e.bin = 0;
            e.pwr = 0;
            for (int i = SKIP; i < m_pwr.size(); i++) begin
                if (m_pwr[i] > e.pwr) begin
                    e.pwr = m_pwr[i];
                    e.bin = longint'(i);
                end
            end
            e.err = (last != at_last) ? 1 : 0;
            m_fcnt++;
            e.fcnt = m_fcnt % 65536;
            e.end_cyc = cyc;
            sb_q.push_back(e);
            m_pwr.delete();
        end
    endtask

    task automatic send_beat(input logic [31:0] re, input logic [31:0] im, input bit last);
        int waited = 0;
        while (gap_en && $urandom_range(0, 1) == 1) begin
            s_axis_tvalid = 1'b0;
            @(posedge clk);
            #1;
        end
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = {im, re};
        s_axis_tlast  = last;
        @(negedge clk);
        while (s_axis_tready !== 1'b1 && waited < 5000) begin
            waited++;
            @(negedge clk);
        end
        if (s_axis_tready !== 1'b1) begin
            fail_now("beat_accept_timeout");
            finish_bench();
        end
        model_accept(re, im, last);
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic send_frame(input int n_beats, input int last_at);
        for (int i = 0; i < n_beats; i++) send_beat(f_re[i], f_im[i], i == last_at);
    endtask

    task automatic clear_frame();
        for (int i = 0; i < N; i++) begin
            f_re[i] = '0;
            f_im[i] = '0;
        end
    endtask

    task automatic random_frame();
        for (int i = 0; i < N; i++) begin
            f_re[i] = $urandom;
            f_im[i] = $urandom;
            // Some small-amplitude bins keep the comparisons interesting.
            if ($urandom_range(0, 3) == 0) begin
                f_re[i] = {{20{f_re[i][11]}}, f_re[i][11:0]};
                f_im[i] = {{20{f_im[i][11]}}, f_im[i][11:0]};
            end
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((sb_q.size() != 0 || peak_valid !== 1'b0) && t < 5000) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (t >= 5000) fail_now("drain_timeout");
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        #1;
        check("rst_tready", 64'(s_axis_tready), 1);
        check("rst_peak_valid", 64'(peak_valid), 0);
        check("rst_peak_bin", 64'(peak_bin), 0);
        check("rst_peak_pwr", peak_pwr, 0);
        check("rst_peak_err", 64'(peak_err), 0);
        check("rst_frame_cnt", 64'(frame_cnt), 0);
        m_pwr.delete();
        sb_q.delete();
        m_fcnt = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Result-ready generator.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       peak_ready = 1'b1;
                1:       peak_ready = 1'b0;
                default: peak_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: latency on each rising result, field compare on each handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_prev = 1'b0;
            end else begin
                if (peak_valid === 1'b1 && !mon_prev) begin
                    if (sb_q.size() == 0) fail_now("unexpected_result");
                    else check("latency_cycle", cyc, sb_q[0].end_cyc + 2);
                end
                if (peak_valid === 1'b1 && peak_ready === 1'b1) begin
                    if (sb_q.size() == 0) begin
                        fail_now("unexpected_handshake");
                    end else begin
                        e = sb_q.pop_front();
                        check("peak_bin", 64'(peak_bin), e.bin);
                        check("peak_pwr", peak_pwr, e.pwr);
                        check("peak_err", 64'(peak_err), e.err);
                        check("frame_cnt", 64'(frame_cnt), e.fcnt);
                    end
                    last_bin  = 64'(peak_bin);
                    last_pwr  = peak_pwr;
                    last_err  = 64'(peak_err);
                    last_fcnt = 64'(frame_cnt);
                end
                mon_prev = (peak_valid === 1'b1);
            end
        end
    end

    initial begin
        #900000;
        fail_now("global_timeout");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "simulation time limit");
    end

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        // Clean tone at bin 37, strong DC that must be ignored.
        clear_frame();
        f_re[37] = 32'h0000_4000;
        f_re[0]  = 32'h7FFF_0000;
        send_frame(N, N - 1);
        wait_drain();
        check("tone_bin", last_bin, 37);
        check("tone_pwr", last_pwr, 64'h1000_0000);
        check("tone_err", last_err, 0);
        check("tone_fcnt", last_fcnt, 1);

        // Tie: lowest index wins.
        clear_frame();
        f_re[10]  = 32'hFFFF_FF00;
        f_im[10]  = 32'h0000_0100;
        f_re[200] = 32'hFFFF_FF00;
        f_im[200] = 32'h0000_0100;
        send_frame(N, N - 1);
        wait_drain();
        check("tie_bin", last_bin, 10);
        check("tie_pwr", last_pwr, 64'h2_0000);

        // Early tlast, then a full frame without tlast.
        random_frame();
        send_frame(100, 99);
        wait_drain();
        check("early_tlast_err", last_err, 1);
        random_frame();
        send_frame(N, -1);
        wait_drain();
        check("missing_tlast_err", last_err, 1);

        // Backpressure: hold result for 50 cycles while source streams.
        rdy_mode = 1;
        fork
            begin
                random_frame();
                send_frame(N, N - 1);
                random_frame();
                send_frame(N, N - 1);
            end
            begin
                int t = 0;
                int viol = 0;
                while (peak_valid !== 1'b1 && t < 3000) begin
                    @(negedge clk);
                    t++;
                end
                if (peak_valid !== 1'b1) begin
                    fail_now("bp_first_result");
                end else begin
                    repeat (50) begin
                        @(negedge clk);
                        if (s_axis_tready !== 1'b0) viol++;
                    end
                    check("bp_tready_low_cycles", 64'(viol), 0);
                end
                rdy_mode = 0;
            end
        join
        wait_drain();

        // Random data, random gaps and random result acceptance.
        do_reset();
        gap_en   = 1'b1;
        rdy_mode = 2;
        repeat (4) begin
            random_frame();
            send_frame(N, N - 1);
        end
        wait_drain();
        check("random_frame_cnt", 64'(frame_cnt), 4);

        // Reset in the middle of a frame.
        gap_en   = 1'b0;
        rdy_mode = 0;
        random_frame();
        send_frame(120, -1);
        do_reset();
        random_frame();
        send_frame(N, N - 1);
        wait_drain();
        check("post_reset_frame_cnt", 64'(frame_cnt), 1);

        repeat (5) @(posedge clk);
        finish_bench();
    end

endmodule
